pl_fetch_ctrl: RTL and testbench
================================

PL_FETCH_CTRL -- requirements
Module: pl_fetch_ctrl

Interface
REQ-001 SHALL provide parameter PROG_CTR_WID, default 10, program counter and instruction-address width.
REQ-002 SHALL provide parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port stall_IF  input  1  hazard hold request from forwarding/hazard control.
REQ-006 SHALL provide port branch_taken_EX  input  1  taken-branch redirect from EX.
REQ-007 SHALL provide port branch_addr_EX  input  PROG_CTR_WID  redirect target, sampled when branch_taken_EX=1.
REQ-008 SHALL provide port instr_mem_out  input  16  instruction word from instruction memory.
REQ-009 SHALL provide port instr_mem_addr  output  PROG_CTR_WID  instruction memory read address.
REQ-010 SHALL provide port instr_mem_en  output  1  instruction memory read enable.
REQ-011 SHALL provide port prog_ctr_IF  output  PROG_CTR_WID  address of the word currently on instr_mem_out.
REQ-012 SHALL provide port fetch_valid  output  1  instr_mem_out holds a valid, non-squashed instruction.
REQ-013 SHALL provide port halted  output  1  fetch stopped on HALT opcode.

Function
REQ-014 Instruction memory SHALL be treated as synchronous, 1-cycle read: address issued in cycle N, data on instr_mem_out in cycle N+1.
REQ-015 FSM SHALL have states BOOT, RUN, REDIRECT, HALT; internal pc_reg holds the next address to issue.
REQ-016 BOOT: instr_mem_addr=pc_reg=RESET_VECTOR, instr_mem_en=1, fetch_valid=0; next state RUN with pc_reg<=RESET_VECTOR+1, prog_ctr_IF<=RESET_VECTOR.
REQ-017 RUN, no stall/branch: instr_mem_addr=pc_reg, instr_mem_en=1, fetch_valid=1; each cycle prog_ctr_IF<=pc_reg, pc_reg<=pc_reg+1.
REQ-018 pc_reg increment SHALL wrap modulo 2^PROG_CTR_WID (all-ones -> 0) with no flag.
REQ-019 RUN with stall_IF=1: instr_mem_addr SHALL be driven combinationally to prog_ctr_IF, pc_reg and prog_ctr_IF held, fetch_valid=1, so instr_mem_out is unchanged next cycle.
REQ-020 branch_taken_EX=1 in BOOT, RUN or HALT: next state REDIRECT, pc_reg<=branch_addr_EX; branch SHALL take priority over stall_IF and HALT detection.
REQ-021 REDIRECT: instr_mem_addr=pc_reg, instr_mem_en=1, fetch_valid=0; next RUN with prog_ctr_IF<=pc_reg, pc_reg<=pc_reg+1 (target word valid one cycle later); branch_taken_EX in REDIRECT restarts REDIRECT with the new target.
REQ-022 RUN, fetch_valid=1, stall_IF=0, branch_taken_EX=0, instr_mem_out[15:11]=OPC_HALT (5'b11111): next state HALT.
REQ-023 HALT: halted=1, instr_mem_en=0, fetch_valid=0, pc_reg and prog_ctr_IF held; exits only via branch_taken_EX or reset.
REQ-024 Redirect penalty SHALL be exactly one fetch_valid=0 cycle after the branch cycle; the squash of the word present in the branch cycle belongs to the IF/ID stage.

Reset
REQ-025 rst=0 SHALL asynchronously force state BOOT, pc_reg=prog_ctr_IF=RESET_VECTOR, instr_mem_addr=RESET_VECTOR, instr_mem_en=0, fetch_valid=0, halted=0.
REQ-026 First rising clk edge with rst=1 SHALL execute BOOT; reset asserted mid-REDIRECT or mid-HALT SHALL discard the pending target.

Structure
REQ-027 Shared package SHALL hold OPC_HALT, opcode field position [15:11], full opcode list, and FSM state encoding.
REQ-028 Block SHALL be a single module with no sub-modules; instr_mem_addr mux is the only combinational output path.

Verification
REQ-029 Reset release, RESET_VECTOR=0, memory word=address -> addr 0,1,2,... one per cycle; fetch_valid rises 1 cycle after BOOT with prog_ctr_IF=0.
REQ-030 stall_IF=1 for 3 cycles at prog_ctr_IF=5 -> instr_mem_addr=5, prog_ctr_IF=5, fetch_valid=1 throughout; resumes with addr 6.
REQ-031 branch_taken_EX=1, branch_addr_EX=0x120 at prog_ctr_IF=7, stall_IF=1 same cycle -> one fetch_valid=0 cycle, then prog_ctr_IF=0x120 valid, then 0x121.
REQ-032 HALT word at address 3 -> halted=1, instr_mem_en=0 from next cycle; later branch to 0x010 -> halted=0, fetch resumes at 0x010.
REQ-033 PROG_CTR_WID=10, branch to 0x3FF -> prog_ctr_IF sequence 0x3FF, 0x000, 0x001.
REQ-034 rst=0 asserted mid-REDIRECT between clock edges -> outputs reach reset values immediately; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/pl_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the opcode field layout, the opcode list and the fetch FSM state encoding.
package pl_fetch_ctrl_pkg;

  localparam int unsigned INSTR_WID = 16;
  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 11;
  localparam int unsigned OPC_WID   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [OPC_WID-1:0] {
    OPC_NOP  = 5'h00,
    OPC_ADD  = 5'h01,
    OPC_SUB  = 5'h02,
    OPC_AND  = 5'h03,
    OPC_OR   = 5'h04,
    OPC_XOR  = 5'h05,
    OPC_SHL  = 5'h06,
    OPC_SHR  = 5'h07,
    OPC_ADDI = 5'h08,
    OPC_LDI  = 5'h09,
    OPC_LD   = 5'h0A,
    OPC_ST   = 5'h0B,
    OPC_BEQ  = 5'h0C,
    OPC_BNE  = 5'h0D,
    OPC_JMP  = 5'h0E,
    OPC_JAL  = 5'h0F,
    OPC_HALT = 5'h1F
  } opcode_e;

  typedef enum logic [1:0] {
    StBoot     = 2'd0,
    StRun      = 2'd1,
    StRedirect = 2'd2,
    StHalt     = 2'd3
  } fetch_state_e;

  function automatic logic [OPC_WID-1:0] get_opcode(input logic [INSTR_WID-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/pl_fetch_ctrl.sv
// Instruction fetch controller for a synchronous 1-cycle instruction memory.
// Handles boot, sequential fetch, hazard stalls, branch redirects and HALT.
module pl_fetch_ctrl
  import pl_fetch_ctrl_pkg::*;
#(
  parameter int unsigned                 PROG_CTR_WID = 10,
  parameter logic [PROG_CTR_WID-1:0]     RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_IF,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_addr_EX,
  input  logic [INSTR_WID-1:0]    instr_mem_out,
  output logic [PROG_CTR_WID-1:0] instr_mem_addr,
  output logic                    instr_mem_en,
  output logic [PROG_CTR_WID-1:0] prog_ctr_IF,
  output logic                    fetch_valid,
  output logic                    halted
);

  localparam logic [PROG_CTR_WID-1:0] PcOne = {{(PROG_CTR_WID-1){1'b0}}, 1'b1};

  fetch_state_e            state_q, state_d;
  logic [PROG_CTR_WID-1:0] pc_q, pc_d;
  logic [PROG_CTR_WID-1:0] prog_ctr_q, prog_ctr_d;
  logic                    unused_operand_bits;

  assign unused_operand_bits = ^instr_mem_out[OPC_LSB-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      prog_ctr_q <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_ctr_q <= prog_ctr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_ctr_d = prog_ctr_q;
    // A taken branch overrides stall and HALT detection in every state.
    if (branch_taken_EX) begin
      state_d = StRedirect;
      pc_d    = branch_addr_EX;
    end else begin
      case (state_q)
        StBoot, StRedirect: begin
          state_d    = StRun;
          prog_ctr_d = pc_q;
          pc_d       = pc_q + PcOne;
        end
        StRun: begin
          if (!stall_IF) begin
            if (get_opcode(instr_mem_out) == OPC_HALT) begin
              state_d = StHalt;
            end else begin
              prog_ctr_d = pc_q;
              pc_d       = pc_q + PcOne;
            end
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StBoot;
        end
      endcase
    end
  end

  // Re-issuing the current address during a stall keeps instr_mem_out stable next cycle.
  assign instr_mem_addr = (state_q == StRun && stall_IF) ? prog_ctr_q : pc_q;
  // Gated by rst so memory stays idle in reset yet reads RESET_VECTOR on the BOOT edge.
  assign instr_mem_en   = rst && (state_q != StHalt);
  assign fetch_valid    = (state_q == StRun);
  assign halted         = (state_q == StHalt);
  assign prog_ctr_IF    = prog_ctr_q;

endmodule

// File: tb/tb_pl_fetch_ctrl.sv
// Self-checking bench for pl_fetch_ctrl with a behavioural fetch model and a
// synchronous instruction memory model.
module tb_pl_fetch_ctrl;

  localparam int unsigned W = 10;
  localparam logic [W-1:0] RV = '0;

  logic         clk;
  logic         rst;
  logic         stall_IF;
  logic         branch_taken_EX;
  logic [W-1:0] branch_addr_EX;
  logic [15:0]  instr_mem_out;
  logic [W-1:0] instr_mem_addr;
  logic         instr_mem_en;
  logic [W-1:0] prog_ctr_IF;
  logic         fetch_valid;
  logic         halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [1024];

  // Model state: what is being presented, what comes next, and the two flags.
  logic         m_valid;
  logic         m_halted;
  logic [W-1:0] m_pc;
  logic [W-1:0] m_next;

  pl_fetch_ctrl #(
    .PROG_CTR_WID (W),
    .RESET_VECTOR (RV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_IF        (stall_IF),
    .branch_taken_EX (branch_taken_EX),
    .branch_addr_EX  (branch_addr_EX),
    .instr_mem_out   (instr_mem_out),
    .instr_mem_addr  (instr_mem_addr),
    .instr_mem_en    (instr_mem_en),
    .prog_ctr_IF     (prog_ctr_IF),
    .fetch_valid     (fetch_valid),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (instr_mem_en) instr_mem_out <= mem[instr_mem_addr];
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
      m_pc     <= RV;
      m_next   <= RV;
    end else if (branch_taken_EX) begin
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
      m_next   <= branch_addr_EX;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (!m_valid) begin
      m_pc    <= m_next;
      m_next  <= m_next + 10'd1;
      m_valid <= 1'b1;
    end else if (stall_IF) begin
      m_valid <= 1'b1;
    end else if (mem[m_pc][15:11] == 5'h1F) begin
      m_halted <= 1'b1;
      m_valid  <= 1'b0;
    end else begin
      m_pc   <= m_next;
      m_next <= m_next + 10'd1;
    end
  end

  function automatic logic [22:0] exp_outs();
    logic [W-1:0] a;
    a = (m_valid && stall_IF) ? m_pc : m_next;
    return {a, rst && !m_halted, m_valid, m_halted, m_pc};
  endfunction

  function automatic logic [22:0] got();
    return {instr_mem_addr, instr_mem_en, fetch_valid, halted, prog_ctr_IF};
  endfunction

  task automatic drive(input logic s, input logic b, input logic [W-1:0] a);
    stall_IF        = s;
    branch_taken_EX = b;
    branch_addr_EX  = a;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (got() !== {RV, 1'b0, 1'b0, 1'b0, RV}) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, got(), {RV, 3'b000, RV});
      end
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, '0);
      n_tests++;
      if (got() !== exp_outs()) begin
        n_fail++;
        $display("FAIL seq cyc=%0d got=%h exp=%h", i, got(), exp_outs());
      end
      if (m_valid) begin
        n_tests++;
        if (instr_mem_out !== mem[m_pc]) begin
          n_fail++;
          $display("FAIL seq_data cyc=%0d got=%h exp=%h", i, instr_mem_out, mem[m_pc]);
        end
      end
      if (i == 1 || i == 5) begin
        n_tests++;
        if ({fetch_valid, prog_ctr_IF} !== {1'b1, 10'(i - 1)}) begin
          n_fail++;
          $display("FAIL seq_pc cyc=%0d got=%h exp=%h", i, {fetch_valid, prog_ctr_IF},
                   {1'b1, 10'(i - 1)});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      drive(i >= 6 && i <= 8, 1'b0, '0);
      n_tests++;
      if (got() !== exp_outs()) begin
        n_fail++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", i, got(), exp_outs());
      end
      if (m_valid) begin
        n_tests++;
        if (instr_mem_out !== mem[m_pc]) begin
          n_fail++;
          $display("FAIL stall_data cyc=%0d got=%h exp=%h", i, instr_mem_out, mem[m_pc]);
        end
      end
      if (i >= 6 && i <= 8) begin
        n_tests++;
        if ({instr_mem_addr, prog_ctr_IF, fetch_valid} !== {10'd5, 10'd5, 1'b1}) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i,
                   {instr_mem_addr, prog_ctr_IF, fetch_valid}, {10'd5, 10'd5, 1'b1});
        end
      end
      if (i == 9) begin
        n_tests++;
        if (instr_mem_addr !== 10'd6) begin
          n_fail++;
          $display("FAIL stall_resume got=%h exp=%h", instr_mem_addr, 10'd6);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      drive(i == 8, i == 8, 10'h120);
      n_tests++;
      if (got() !== exp_outs()) begin
        n_fail++;
        $display("FAIL branch cyc=%0d got=%h exp=%h", i, got(), exp_outs());
      end
      if (m_valid) begin
        n_tests++;
        if (instr_mem_out !== mem[m_pc]) begin
          n_fail++;
          $display("FAIL branch_data cyc=%0d got=%h exp=%h", i, instr_mem_out, mem[m_pc]);
        end
      end
      if (i == 9 || i == 10 || i == 11) begin
        n_tests++;
        if ({fetch_valid, prog_ctr_IF} !== ((i == 9) ? {1'b0, 10'd7} : {1'b1, 10'(i + 'h116)})) begin
          n_fail++;
          $display("FAIL branch_seq cyc=%0d got=%h", i, {fetch_valid, prog_ctr_IF});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    mem[3] = 16'hF803;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, i == 8, 10'h010);
      n_tests++;
      if (got() !== exp_outs()) begin
        n_fail++;
        $display("FAIL halt cyc=%0d got=%h exp=%h", i, got(), exp_outs());
      end
      if (i >= 5 && i <= 8) begin
        n_tests++;
        if ({halted, instr_mem_en, fetch_valid} !== 3'b100) begin
          n_fail++;
          $display("FAIL halt_flags cyc=%0d got=%b exp=100", i, {halted, instr_mem_en, fetch_valid});
        end
      end
      if (i == 10) begin
        n_tests++;
        if ({halted, fetch_valid, prog_ctr_IF, instr_mem_out} !== {2'b01, 10'h010, 16'h0010}) begin
          n_fail++;
          $display("FAIL halt_resume got=%h", {halted, fetch_valid, prog_ctr_IF, instr_mem_out});
        end
      end
      @(negedge clk);
    end
    mem[3] = 16'h0003;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, i == 3, 10'h3FF);
      n_tests++;
      if (got() !== exp_outs()) begin
        n_fail++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", i, got(), exp_outs());
      end
      if (i >= 5 && i <= 7) begin
        n_tests++;
        if ({fetch_valid, prog_ctr_IF} !== {1'b1, 10'(i + 'h3FA)}) begin
          n_fail++;
          $display("FAIL wrap_seq cyc=%0d got=%h exp=%h", i, {fetch_valid, prog_ctr_IF},
                   {1'b1, 10'(i + 'h3FA)});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_redirect();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i == 4, 10'h200);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, '0);
    n_tests++;
    if ({instr_mem_addr, fetch_valid} !== {10'h200, 1'b0}) begin
      n_fail++;
      $display("FAIL redirect_pre got=%h exp=%h", {instr_mem_addr, fetch_valid}, {10'h200, 1'b0});
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (got() !== {RV, 1'b0, 1'b0, 1'b0, RV}) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", got(), {RV, 3'b000, RV});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0);
      n_tests++;
      if (got() !== exp_outs()) begin
        n_fail++;
        $display("FAIL restart cyc=%0d got=%h exp=%h", i, got(), exp_outs());
      end
      if (i == 1) begin
        n_tests++;
        if ({fetch_valid, prog_ctr_IF} !== {1'b1, RV}) begin
          n_fail++;
          $display("FAIL restart_pc got=%h exp=%h", {fetch_valid, prog_ctr_IF}, {1'b1, RV});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(9) == 0, 10'($urandom));
      n_tests++;
      if (got() !== exp_outs()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, got(), exp_outs());
      end
      if (m_valid) begin
        n_tests++;
        if (instr_mem_out !== mem[m_pc]) begin
          n_fail++;
          $display("FAIL random_data cyc=%0d got=%h exp=%h", i, instr_mem_out, mem[m_pc]);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst             = 1'b0;
    stall_IF        = 1'b0;
    branch_taken_EX = 1'b0;
    branch_addr_EX  = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_mid_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
